serial_pattern_gen: RTL and testbench

- Serial bit-stream transmitter; the source side of the team's serial sequence detectors (e.g. the "01" detector).
- Accepts a parallel pattern word, shifts it out one bit per clock MSB-first, then optionally appends pseudo-random filler bits from an internal 5-bit LFSR.
- Keeps a running count of the "0 then 1" pairs it emitted. A bench compares this count directly against the detector's hit count.

---
 rtl/serial_pattern_gen_if.sv | 26 ++
 rtl/serial_pattern_gen.sv | 156 +++++++++++++++
 tb/tb_serial_pattern_gen.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/serial_pattern_gen_if.sv
// Bundle of the pattern request inputs and serial stream outputs of serial_pattern_gen.
// The master drives the request and the slave (the generator) drives the stream.
interface serial_pattern_gen_if #(
    parameter int W     = 8,
    parameter int CNT_W = 8
);
    logic             start;
    logic [W-1:0]     pat;
    logic [4:0]       len;
    logic [3:0]       gap;
    logic             A;
    logic             bit_valid;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] exp_cnt;

    modport master (
        output start, pat, len, gap,
        input  A, bit_valid, busy, done, exp_cnt
    );

    modport slave (
        input  start, pat, len, gap,
        output A, bit_valid, busy, done, exp_cnt
    );
endinterface

// File: rtl/serial_pattern_gen.sv
// Serial bit-stream source: shifts a latched pattern out MSB-first, appends LFSR filler
// bits, and counts the 0->1 pairs it emitted so a detector's hit count can be checked.
module serial_pattern_gen #(
    parameter int W     = 8,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    serial_pattern_gen_if.slave bus
);
    localparam int         IW  = (W > 1) ? $clog2(W) : 1;
    localparam logic [4:0] W_L = 5'(W);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_reg, state_next;
    logic [W-1:0]     pat_reg, pat_next;
    logic [IW-1:0]    idx_reg, idx_next;
    logic [3:0]       gcnt_reg, gcnt_next;
    logic             a_reg, a_next;
    logic             valid_reg, valid_next;
    logic             prev_bit_reg, prev_valid_reg;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [4:0]       lfsr_reg, lfsr_next;

    logic [4:0]       eff_len;
    logic [IW-1:0]    idx_first;
    logic [IW-1:0]    idx_dec;
    logic             pair;

    always_comb begin
        eff_len   = (bus.len > W_L) ? W_L : bus.len;
        idx_first = IW'(eff_len - 5'd1);
        idx_dec   = idx_reg - 1'b1;
    end

    // Free-running filler source; XNOR feedback keeps the all-zero seed from locking up.
    always_comb begin
        lfsr_next = {lfsr_reg[3:0], ~(lfsr_reg[2] ^ lfsr_reg[4])};
    end

    // Next-state logic also produces the next stream bit, so A and bit_valid come
    // straight out of flops and the first pattern bit appears one cycle after start.
    always_comb begin
        state_next = state_reg;
        pat_next   = pat_reg;
        idx_next   = idx_reg;
        gcnt_next  = gcnt_reg;
        a_next     = 1'b0;
        valid_next = 1'b0;

        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    pat_next  = bus.pat;
                    gcnt_next = bus.gap;
                    if (eff_len != 5'd0) begin
                        state_next = SHIFT;
                        idx_next   = idx_first;
                        a_next     = bus.pat[idx_first];
                        valid_next = 1'b1;
                    end else if (bus.gap != 4'd0) begin
                        state_next = GAP;
                        gcnt_next  = bus.gap - 4'd1;
                        a_next     = lfsr_reg[0];
                        valid_next = 1'b1;
                    end else begin
                        state_next = DONE;
                    end
                end
            end

            SHIFT: begin
                if (idx_reg != '0) begin
                    idx_next   = idx_dec;
                    a_next     = pat_reg[idx_dec];
                    valid_next = 1'b1;
                end else if (gcnt_reg != 4'd0) begin
                    state_next = GAP;
                    gcnt_next  = gcnt_reg - 4'd1;
                    a_next     = lfsr_reg[0];
                    valid_next = 1'b1;
                end else begin
                    state_next = DONE;
                end
            end

            // gcnt holds the filler bits still owed after the one currently on A
            GAP: begin
                if (gcnt_reg != 4'd0) begin
                    gcnt_next  = gcnt_reg - 4'd1;
                    a_next     = lfsr_reg[0];
                    valid_next = 1'b1;
                end else begin
                    state_next = DONE;
                end
            end

            DONE: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // A pair only counts when both bits are valid and adjacent; an idle or DONE cycle
    // clears prev_valid, so bits of different bursts never pair up.
    always_comb begin
        pair     = valid_next & a_next & prev_valid_reg & ~prev_bit_reg;
        cnt_next = cnt_reg;
        if (pair && (cnt_reg != {CNT_W{1'b1}})) begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            pat_reg        <= '0;
            idx_reg        <= '0;
            gcnt_reg       <= '0;
            a_reg          <= 1'b0;
            valid_reg      <= 1'b0;
            prev_bit_reg   <= 1'b0;
            prev_valid_reg <= 1'b0;
            cnt_reg        <= '0;
            lfsr_reg       <= 5'b00000;
        end else begin
            state_reg      <= state_next;
            pat_reg        <= pat_next;
            idx_reg        <= idx_next;
            gcnt_reg       <= gcnt_next;
            a_reg          <= a_next;
            valid_reg      <= valid_next;
            prev_bit_reg   <= a_next;
            prev_valid_reg <= valid_next;
            cnt_reg        <= cnt_next;
            lfsr_reg       <= lfsr_next;
        end
    end

    assign bus.A         = a_reg;
    assign bus.bit_valid = valid_reg;
    assign bus.busy      = (state_reg != IDLE);
    assign bus.done      = (state_reg == DONE);
    assign bus.exp_cnt   = cnt_reg;

endmodule

// File: tb/tb_serial_pattern_gen.sv
// Directed bench for serial_pattern_gen: bursts with hand-computed patterns and
// pair counts, LFSR filler checked against a reference LFSR run from reset.
module tb_serial_pattern_gen;
    localparam int W     = 8;
    localparam int CNT_W = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    serial_pattern_gen_if #(.W(W), .CNT_W(CNT_W)) bus ();

    serial_pattern_gen #(.W(W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int       checks = 0;
    int       errors = 0;
    int       cnt_m  = 0;
    int       base   = 0;
    logic     pv     = 1'b0;
    logic     pb     = 1'b0;
    logic [4:0] lfsr_m;

    // Reference LFSR: seed 0, same taps, advances on every edge outside reset
    always @(posedge clk or posedge rst) begin
        if (rst) lfsr_m <= 5'b00000;
        else     lfsr_m <= {lfsr_m[3:0], ~(lfsr_m[2] ^ lfsr_m[4])};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic bit_chk(input string tag, input logic a);
        if (pv && !pb && a && cnt_m < 255) cnt_m++;
        pb = a;
        pv = 1'b1;
        chk({tag, "_A"},     32'(bus.A), 32'(a));
        chk({tag, "_valid"}, 32'(bus.bit_valid), 32'd1);
        chk({tag, "_busy"},  32'(bus.busy), 32'd1);
        chk({tag, "_done"},  32'(bus.done), 32'd0);
        chk({tag, "_cnt"},   32'(bus.exp_cnt), 32'(cnt_m));
    endtask

    task automatic done_chk(input string tag);
        pv = 1'b0;
        chk({tag, "_A"},     32'(bus.A), 32'd0);
        chk({tag, "_valid"}, 32'(bus.bit_valid), 32'd0);
        chk({tag, "_busy"},  32'(bus.busy), 32'd1);
        chk({tag, "_done"},  32'(bus.done), 32'd1);
        chk({tag, "_cnt"},   32'(bus.exp_cnt), 32'(cnt_m));
    endtask

    task automatic idle_chk(input string tag);
        pv = 1'b0;
        chk({tag, "_A"},     32'(bus.A), 32'd0);
        chk({tag, "_valid"}, 32'(bus.bit_valid), 32'd0);
        chk({tag, "_busy"},  32'(bus.busy), 32'd0);
        chk({tag, "_done"},  32'(bus.done), 32'd0);
    endtask

    // Starts a burst from an IDLE negedge; ends on the negedge of the following IDLE cycle.
    task automatic run_burst(input string tag, input logic [W-1:0] p, input int l, input int g);
        int         eff;
        logic [4:0] lf_prev;
        eff       = (l > W) ? W : l;
        bus.pat   = p;
        bus.len   = 5'(l);
        bus.gap   = 4'(g);
        bus.start = 1'b1;
        lf_prev   = lfsr_m;
        for (int k = 0; k < eff + g; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            bit_chk($sformatf("%s_b%0d", tag, k), (k < eff) ? p[eff-1-k] : lf_prev[0]);
            lf_prev = lfsr_m;
        end
        @(negedge clk);
        bus.start = 1'b0;
        done_chk({tag, "_done"});
        @(negedge clk);
        idle_chk({tag, "_idle"});
        $display("burst %s: pat=%0h len=%0d gap=%0d exp_cnt=%0d", tag, p, l, g, bus.exp_cnt);
    endtask

    initial begin
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.pat   = '0;
        bus.len   = '0;
        bus.gap   = '0;
        #2;
        idle_chk("reset");
        chk("reset_cnt", 32'(bus.exp_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        idle_chk("post_reset");

        // 1: full 8-bit pattern 0101_0011 -> three 0->1 pairs
        run_burst("s1", 8'b0101_0011, 8, 0);
        chk("s1_total", 32'(bus.exp_cnt), 32'd3);

        // 2: short pattern 101 adds one pair; len=20 clamps to 8 (11111101) adds one
        run_burst("s2a", 8'hFD, 3, 0);
        chk("s2a_total", 32'(bus.exp_cnt), 32'd4);
        run_burst("s2b", 8'hFD, 20, 0);
        chk("s2b_total", 32'(bus.exp_cnt), 32'd5);

        // 3: pattern 01 followed by five LFSR filler bits
        run_burst("s3", 8'h01, 2, 5);

        // 4: restarts ignored mid-burst; held start launches the next burst after IDLE.
        // Burst 1 ends in 0 and burst 2 starts with 1: that boundary must not count.
        base      = cnt_m;
        bus.pat   = 8'h0A;
        bus.len   = 5'd4;
        bus.gap   = 4'd0;
        bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;               bit_chk("s4_b0", 1'b1);
        @(negedge clk); bus.start = 1'b1; bus.pat = 8'h0D; bit_chk("s4_b1", 1'b0);
        @(negedge clk); bus.start = 1'b0;               bit_chk("s4_b2", 1'b1);
        @(negedge clk); bus.start = 1'b1;               bit_chk("s4_b3", 1'b0);
        @(negedge clk); done_chk("s4_done1");
        @(negedge clk); idle_chk("s4_idle");
        @(negedge clk); bus.start = 1'b0;               bit_chk("s4_c0", 1'b1);
        @(negedge clk); bit_chk("s4_c1", 1'b1);
        @(negedge clk); bit_chk("s4_c2", 1'b0);
        @(negedge clk); bit_chk("s4_c3", 1'b1);
        @(negedge clk); done_chk("s4_done2");
        @(negedge clk); idle_chk("s4_idle2");
        chk("s4_total", 32'(bus.exp_cnt), 32'(base + 2));
        $display("burst s4: two back-to-back bursts exp_cnt=%0d", bus.exp_cnt);

        // 5: empty burst goes straight to DONE
        base = cnt_m;
        run_burst("s5", 8'hFF, 0, 0);
        chk("s5_total", 32'(bus.exp_cnt), 32'(base));

        // 6: asynchronous reset in the middle of SHIFT
        bus.pat   = 8'b0101_0011;
        bus.len   = 5'd8;
        bus.gap   = 4'd0;
        bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0; bit_chk("s6_b0", 1'b0);
        @(negedge clk); bit_chk("s6_b1", 1'b1);
        @(negedge clk); bit_chk("s6_b2", 1'b0);
        #2 rst = 1'b1;
        #1;
        cnt_m = 0;
        pv    = 1'b0;
        idle_chk("s6_rst");
        chk("s6_rst_cnt", 32'(bus.exp_cnt), 32'd0);
        @(negedge clk);
        idle_chk("s6_rst_hold");
        rst = 1'b0;
        @(negedge clk);
        idle_chk("s6_released");
        run_burst("s6_fresh", 8'b0101_0011, 8, 0);
        chk("s6_total", 32'(bus.exp_cnt), 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
